// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the dcache write buffer
package wb_pkg;

   typedef enum logic [2:0] {
      WB_IDLE    = 3'b001,
      WB_REQ     = 3'b010,
      WB_WAIT_OK = 3'b100
   } wb_state_e;

   localparam logic WB_TYPE_WORD = 1'b0;
   localparam logic WB_TYPE_LINE = 1'b1;

   localparam int WB_LINE_OFS = 4;
   localparam int WB_ADDR_W   = 32;
   localparam int WB_SIZE_W   = 3;
   localparam int WB_STRB_W   = 4;
   localparam int WB_DATA_W   = 128;

   typedef struct packed {
      logic                 typ;
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_SIZE_W-1:0] size;
      logic [WB_STRB_W-1:0] wstrb;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo_mem.sv
// rtl/wb_fifo_mem.sv - entry register file with head read, line-compare vector
// and, under WB_MERGE_EN, a read port for the most recently allocated entry
module wb_fifo_mem
   import wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                               clk,
   input  logic                               we_i,
   input  logic [AW-1:0]                      waddr_i,
   input  wb_entry_t                          wentry_i,
   input  logic [AW-1:0]                      head_i,
   output wb_entry_t                          head_o,
`ifdef WB_MERGE_EN
   input  logic [AW-1:0]                      last_i,
   output wb_entry_t                          last_o,
`endif
   input  logic [WB_ADDR_W-1:WB_LINE_OFS]     query_line_i,
   output logic [DEPTH-1:0]                   match_o
);

   wb_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wentry_i;
      end
   end

   assign head_o = mem_q[head_i];
`ifdef WB_MERGE_EN
   assign last_o = mem_q[last_i];
`endif

   // Raw per-slot compare; the caller masks it with slot validity.
   always_comb begin
      match_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_o[i] = (mem_q[i].addr[WB_ADDR_W-1:WB_LINE_OFS] == query_line_i);
      end
   end

endmodule

// File: rtl/dcache_wr_buffer.sv
// rtl/dcache_wr_buffer.sv - dcache write buffer draining to the AXI bridge one write at a time;
// define WB_MERGE_EN to merge word stores into the youngest word entry
module dcache_wr_buffer
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic         push_type,
   input  logic [31:0]  push_addr,
   input  logic [2:0]   push_size,
   input  logic [3:0]   push_wstrb,
   input  logic [127:0] push_data,
   input  logic [31:0]  query_addr,
   output logic         query_hit,
   output logic         empty,
   output logic         wr_req,
   output logic         wr_type,
   output logic [31:0]  wr_addr,
   output logic [2:0]   wr_size,
   output logic [3:0]   wr_wstrb,
   output logic [127:0] wr_data,
   input  logic         wr_rdy,
   input  logic         wr_ok
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   wb_state_e       state_q, state_d;
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [PW-1:0]   count;
   logic            full;
   logic [DEPTH-1:0] valid, match;
   logic [AW-1:0]   slot_ofs;
   logic            merge_ok, push_fire, alloc, pop;
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   wb_entry_t       push_entry, mem_wentry, head_entry;
   logic            unused_query_ofs;

   assign count = tail_q - head_q;
   assign full  = (count == PW'(DEPTH));
   assign empty = (count == '0);

   // A slot is live when its distance from head is below the occupancy.
   always_comb begin
      valid    = '0;
      slot_ofs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_ofs = AW'(i) - head_q[AW-1:0];
         valid[i] = ({1'b0, slot_ofs} < count);
      end
   end

   always_comb begin
      push_entry       = '0;
      push_entry.typ   = push_type;
      push_entry.addr  = push_addr;
      push_entry.size  = (push_type == WB_TYPE_LINE) ? 3'd2 : push_size;
      push_entry.wstrb = (push_type == WB_TYPE_LINE) ? 4'b1111 : push_wstrb;
      push_entry.data  = push_data;
   end

`ifdef WB_MERGE_EN
   logic [AW-1:0] last_idx;
   wb_entry_t     last_entry, merged_entry;

   assign last_idx = tail_q[AW-1:0] - 1'b1;

   // The head entry may already be on the bus, so it is never rewritten then.
   assign merge_ok = push_valid && (push_type == WB_TYPE_WORD) && (count != '0)
                     && (last_entry.typ == WB_TYPE_WORD)
                     && (last_entry.addr[31:2] == push_addr[31:2])
                     && !((count == PW'(1)) && (state_q != WB_IDLE));

   always_comb begin
      merged_entry = last_entry;
      for (int b = 0; b < 4; b++) begin
         if (push_wstrb[b]) begin
            merged_entry.data[8*b +: 8] = push_data[8*b +: 8];
         end
      end
      merged_entry.wstrb = last_entry.wstrb | push_wstrb;
      merged_entry.size  = 3'd2;
   end

   assign mem_waddr  = merge_ok ? last_idx : tail_q[AW-1:0];
   assign mem_wentry = merge_ok ? merged_entry : push_entry;
`else
   assign merge_ok   = 1'b0;
   assign mem_waddr  = tail_q[AW-1:0];
   assign mem_wentry = push_entry;
`endif

   assign push_ready = !full || merge_ok;
   assign push_fire  = push_valid && push_ready;
   assign alloc      = push_fire && !merge_ok;
   assign pop        = (state_q == WB_WAIT_OK) && wr_ok;
   assign mem_we     = push_fire;

   assign head_d = head_q + PW'(pop);
   assign tail_d = tail_q + PW'(alloc);

   wb_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk          (clk),
      .we_i         (mem_we),
      .waddr_i      (mem_waddr),
      .wentry_i     (mem_wentry),
      .head_i       (head_q[AW-1:0]),
      .head_o       (head_entry),
`ifdef WB_MERGE_EN
      .last_i       (last_idx),
      .last_o       (last_entry),
`endif
      .query_line_i (query_addr[31:WB_LINE_OFS]),
      .match_o      (match)
   );

   assign query_hit = (|(match & valid))
                      || (push_fire && (push_addr[31:WB_LINE_OFS] == query_addr[31:WB_LINE_OFS]));
   assign unused_query_ofs = ^query_addr[WB_LINE_OFS-1:0];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= WB_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WB_IDLE:    if (count != '0) state_d = WB_REQ;
         WB_REQ:     if (wr_rdy)      state_d = WB_WAIT_OK;
         WB_WAIT_OK: if (wr_ok)       state_d = WB_IDLE;
         default:                     state_d = WB_IDLE;
      endcase
   end

   always_comb begin
      wr_req   = (state_q == WB_REQ);
      wr_type  = head_entry.typ;
      wr_addr  = head_entry.addr;
      wr_size  = head_entry.size;
      wr_wstrb = head_entry.wstrb;
      wr_data  = head_entry.data;
   end

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// tb/tb_dcache_wr_buffer.sv - scoreboard bench for dcache_wr_buffer (covers WB_MERGE_EN when defined)
module tb_dcache_wr_buffer;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         resetn;
   logic         push_valid;
   logic         push_ready;
   logic         push_type;
   logic [31:0]  push_addr;
   logic [2:0]   push_size;
   logic [3:0]   push_wstrb;
   logic [127:0] push_data;
   logic [31:0]  query_addr;
   logic         query_hit;
   logic         empty;
   logic         wr_req;
   logic         wr_type;
   logic [31:0]  wr_addr;
   logic [2:0]   wr_size;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;
   logic         wr_ok;

   typedef struct {
      logic         typ;
      logic [31:0]  addr;
      logic [2:0]   size;
      logic [3:0]   wstrb;
      logic [127:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   dcache_wr_buffer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .push_type  (push_type),
      .push_addr  (push_addr),
      .push_size  (push_size),
      .push_wstrb (push_wstrb),
      .push_data  (push_data),
      .query_addr (query_addr),
      .query_hit  (query_hit),
      .empty      (empty),
      .wr_req     (wr_req),
      .wr_type    (wr_type),
      .wr_addr    (wr_addr),
      .wr_size    (wr_size),
      .wr_wstrb   (wr_wstrb),
      .wr_data    (wr_data),
      .wr_rdy     (wr_rdy),
      .wr_ok      (wr_ok)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle push; exp_qh < 0 skips the same-cycle query check.
   task automatic do_push(input logic typ, input logic [31:0] addr, input logic [2:0] size,
                          input logic [3:0] wstrb, input logic [127:0] data, input logic exp_acc,
                          input logic sb, input logic with_ok, input int exp_qh);
      exp_t e;
      push_valid = 1'b1;
      push_type  = typ;
      push_addr  = addr;
      push_size  = size;
      push_wstrb = wstrb;
      push_data  = data;
      wr_ok      = with_ok;
      @(negedge clk);
      check("push_ready", push_ready, exp_acc);
      if (exp_qh >= 0) check("query_hit_push", query_hit, exp_qh[0]);
      if (exp_acc && sb) begin
         e.typ   = typ;
         e.addr  = addr;
         e.size  = typ ? 3'd2 : size;
         e.wstrb = typ ? 4'hF : wstrb;
         e.data  = data;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      push_valid = 1'b0;
      wr_ok      = 1'b0;
   endtask

   task automatic serve_req(input int stall);
      int t = 0;
      while (!wr_req && t < 40) begin
         tick();
         t++;
      end
      check("wr_req_seen", wr_req, 1'b1);
      for (int i = 0; i < stall; i++) begin
         tick();
         check("wr_req_hold", wr_req, 1'b1);
      end
      wr_rdy = 1'b1;
      tick();
      wr_rdy = 1'b0;
   endtask

   task automatic give_ok(input int dly);
      repeat (dly) tick();
      wr_ok = 1'b1;
      tick();
      wr_ok = 1'b0;
   endtask

   // Monitor: every accepted bridge request must match the oldest expected write.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn && wr_req && wr_rdy) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL sb_unexpected_wr: got addr 0x%0h, expected no write", wr_addr);
            end else begin
               e = exp_q.pop_front();
               check("wr_type",  wr_type,  e.typ);
               check("wr_addr",  wr_addr,  e.addr);
               check("wr_size",  wr_size,  e.size);
               check("wr_wstrb", wr_wstrb, e.wstrb);
               check("wr_data",  wr_data,  e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      resetn     = 1'b0;
      push_valid = 1'b0;
      push_type  = 1'b0;
      push_addr  = '0;
      push_size  = '0;
      push_wstrb = '0;
      push_data  = '0;
      query_addr = '0;
      wr_rdy     = 1'b0;
      wr_ok      = 1'b0;
      tick();
      tick();
      check("rst_push_ready", push_ready, 1'b1);
      check("rst_wr_req",     wr_req,     1'b0);
      check("rst_empty",      empty,      1'b1);
      check("rst_query_hit",  query_hit,  1'b0);
      resetn = 1'b1;
      tick();

      // Single word store with stalled wr_rdy
      do_push(1'b0, 32'h1FC0_0010, 3'd1, 4'b0011, 128'h0000_BEEF, 1'b1, 1'b1, 1'b0, -1);
      check("word_wr_req_c1", wr_req, 1'b0);
      check("word_empty_c1",  empty,  1'b0);
      tick();
      check("word_wr_req_c2", wr_req, 1'b1);
      serve_req(3);
      check("word_empty_wait", empty, 1'b0);
      tick();
      wr_ok = 1'b1;
      check("word_empty_at_ok", empty, 1'b0);
      tick();
      wr_ok = 1'b0;
      check("word_empty_after_ok", empty, 1'b1);

      // Four lines fill DEPTH=4; fifth refused; drain in order
      do_push(1'b1, 32'h0000_1000, 3'd0, 4'b0000, {4{32'h1111_0000}}, 1'b1, 1'b1, 1'b0, -1);
      do_push(1'b1, 32'h0000_2000, 3'd7, 4'b1010, {4{32'h2222_0001}}, 1'b1, 1'b1, 1'b0, -1);
      do_push(1'b1, 32'h0000_3000, 3'd0, 4'b0001, {4{32'h3333_0002}}, 1'b1, 1'b1, 1'b0, -1);
      do_push(1'b1, 32'h0000_4000, 3'd5, 4'b0000, {4{32'h4444_0003}}, 1'b1, 1'b1, 1'b0, -1);
      do_push(1'b1, 32'h0000_5000, 3'd0, 4'b0000, {4{32'h5555_0004}}, 1'b0, 1'b1, 1'b0, -1);
      serve_req(0);
      give_ok(1);
      check("next_req_n1", wr_req, 1'b0);
      tick();
      check("next_req_n2", wr_req, 1'b1);
      for (int i = 0; i < 3; i++) begin
         serve_req(0);
         give_ok(0);
      end
      check("fill_empty", empty, 1'b1);

      // Line-granular address query
      query_addr = 32'h0000_1238;
      do_push(1'b1, 32'h0000_1230, 3'd0, 4'b0000, {4{32'hCAFE_F00D}}, 1'b1, 1'b1, 1'b0, 1);
      query_addr = 32'h0000_123C;
      #1 check("query_same_line", query_hit, 1'b1);
      query_addr = 32'h0000_1240;
      #1 check("query_next_line", query_hit, 1'b0);
      query_addr = 32'h0000_123C;
      serve_req(0);
      check("query_in_flight", query_hit, 1'b1);
      give_ok(0);
      check("query_after_ok", query_hit, 1'b0);

      // Full buffer: push in the same cycle as wr_ok is refused
      do_push(1'b1, 32'h0000_A000, 3'd0, 4'b0000, {4{32'hA0A0_A0A0}}, 1'b1, 1'b1, 1'b0, -1);
      do_push(1'b1, 32'h0000_B000, 3'd0, 4'b0000, {4{32'hB0B0_B0B0}}, 1'b1, 1'b1, 1'b0, -1);
      do_push(1'b1, 32'h0000_C000, 3'd0, 4'b0000, {4{32'hC0C0_C0C0}}, 1'b1, 1'b1, 1'b0, -1);
      do_push(1'b1, 32'h0000_D000, 3'd0, 4'b0000, {4{32'hD0D0_D0D0}}, 1'b1, 1'b1, 1'b0, -1);
      serve_req(0);
      do_push(1'b1, 32'h0000_E000, 3'd0, 4'b0000, {4{32'hE0E0_E0E0}}, 1'b0, 1'b1, 1'b1, -1);
      do_push(1'b1, 32'h0000_F000, 3'd0, 4'b0000, {4{32'hF0F0_F0F0}}, 1'b1, 1'b1, 1'b0, -1);
      for (int i = 0; i < 4; i++) begin
         serve_req(0);
         give_ok(0);
      end
      check("full_empty", empty, 1'b1);

`ifdef WB_MERGE_EN
      begin
         exp_t m;
         do_push(1'b0, 32'h0000_0100, 3'd0, 4'b0001, 128'h0000_00AA, 1'b1, 1'b0, 1'b0, -1);
         do_push(1'b0, 32'h0000_0100, 3'd0, 4'b0100, 128'h00CC_0000, 1'b1, 1'b0, 1'b0, -1);
         m.typ   = 1'b0;
         m.addr  = 32'h0000_0100;
         m.size  = 3'd2;
         m.wstrb = 4'b0101;
         m.data  = 128'h00CC_00AA;
         exp_q.push_back(m);
         serve_req(0);
         give_ok(0);
         check("merge_single_entry", empty, 1'b1);
      end
`endif

      // Reset while a write is outstanding
      do_push(1'b1, 32'h0000_7000, 3'd0, 4'b0000, {4{32'h7777_7777}}, 1'b1, 1'b1, 1'b0, -1);
      do_push(1'b1, 32'h0000_8000, 3'd0, 4'b0000, {4{32'h8888_8888}}, 1'b1, 1'b1, 1'b0, -1);
      do_push(1'b1, 32'h0000_9000, 3'd0, 4'b0000, {4{32'h9999_9999}}, 1'b1, 1'b1, 1'b0, -1);
      serve_req(0);
      resetn = 1'b0;
      tick();
      check("rst_mid_empty",      empty,      1'b1);
      check("rst_mid_wr_req",     wr_req,     1'b0);
      check("rst_mid_push_ready", push_ready, 1'b1);
      exp_q.delete();
      resetn = 1'b1;
      tick();
      check("rst_mid_idle_1", wr_req, 1'b0);
      tick();
      check("rst_mid_idle_2", wr_req, 1'b0);

      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dcache_wr_buffer.md
# dcache_wr_buffer

Write buffer between the data cache and the cache-to-AXI bridge. Queues dirty-line writebacks and uncached word stores from the dcache, drains them one at a time through the bridge's `data_wr_*` handshake, and holds each entry until its AXI write response returns. Exposes an address-match query so the dcache can stall reads that would bypass a pending write to the same line.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; a power of two, at least 2.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `push_valid` in 1: the dcache offers a write.
- `push_ready` out 1: the buffer accepts the write this cycle.
- `push_type` in 1: 0 = single word (data in `push_data[31:0]`), 1 = 16-byte line.
- `push_addr` in 32: byte address.
- `push_size` in 3: AXI size (word type only).
- `push_wstrb` in 4: byte strobes (word type only).
- `push_data` in 128: write data.
- `query_addr` in 32: dcache read-miss address.
- `query_hit` out 1: a pending write covers the same line.
- `empty` out 1: no entries held, including in-flight entries.
- `wr_req` out 1: to bridge `data_wr_req`.
- `wr_type` out 1: to bridge `data_wr_type`.
- `wr_addr` out 32: to bridge `data_wr_addr`.
- `wr_size` out 3: to bridge `data_wr_size`.
- `wr_wstrb` out 4: to bridge `data_wr_wstrb`.
- `wr_data` out 128: to bridge `data_wr_data`.
- `wr_rdy` in 1: from bridge `data_wr_rdy`.
- `wr_ok` in 1: from bridge `data_wr_ok`; one-cycle pulse per completed write.

## Operation
- Storage is a circular FIFO of `DEPTH` entries. Each entry holds {type, addr, size, wstrb, data}.
- `head` and `tail` pointers are log2(DEPTH)+1 bits wide; the extra bit is the wrap flag.
- `count = tail - head`. Full when `count == DEPTH`; `empty = (count == 0)`.
- Push: `push_valid && push_ready` writes the entry at `tail` and increments `tail`. `push_ready = !full`, or the merge condition when merging is enabled.
- A line push forces size 3'd2 and strobes 4'b1111 in the stored entry.
- Drain FSM, one-hot, three states:
  - IDLE: if `count != 0`, go to REQ.
  - REQ: `wr_req = 1`; all `wr_*` fields are driven combinationally from the `head` entry. On `wr_rdy`, go to WAIT_OK.
  - WAIT_OK: on `wr_ok`, increment `head` and go to IDLE.
- Only one write is outstanding at a time, and the head entry is not freed until `wr_ok` arrives.
- `query_hit` is the OR, over all valid entries and over a push accepted in the same cycle, of `entry.addr[31:4] == query_addr[31:4]`. Word entries are compared at line granularity (conservative).
- A push and a pop in the same cycle are both honoured; `count` is unchanged.
- Full: pushes are refused even if a pop happens in the same cycle, except for a merge.
- Reset mid-operation clears the pointers and forces IDLE. Any in-flight write is discarded; the bridge is reset at the same time.

## Timing
- Reset values: `push_ready = 1`, `wr_req = 0`, `empty = 1`, `query_hit = 0` when `push_valid = 0`; the `wr_*` fields are don't-care.
- A push accepted in cycle 0 into an empty buffer gives `count = 1` in cycle 1 and `wr_req = 1` in cycle 2.
- `wr_req` stays high, with stable fields, until `wr_rdy`.
- After `wr_ok` in cycle n, the next entry's `wr_req` rises in cycle n+2 (via IDLE).
- `query_hit` is combinational from `query_addr`, the push signals, and the registered entries.

## Configuration
- `WB_MERGE_EN` defined: a word push merges into the `tail-1` entry when all of the following hold:
  - that entry is word type;
  - `addr[31:2]` matches;
  - that entry is not the head entry while the FSM is in REQ or WAIT_OK.
- A merge overwrites the bytes selected by `push_wstrb`, ORs the strobes, and sets size to 3'd2. `tail` does not move. A merge is accepted even when the buffer is full.
- `WB_MERGE_EN` undefined: every push allocates a new entry, and `push_ready = !full`.

## Structure
- Shared package `wb_pkg`:
  - FSM state encodings WB_IDLE, WB_REQ, WB_WAIT_OK;
  - type constants WB_TYPE_WORD = 1'b0, WB_TYPE_LINE = 1'b1;
  - line-offset width constant WB_LINE_OFS = 4;
  - entry field widths.
- One sub-module, `wb_fifo_mem`: `DEPTH` x entry register file with one write port, a combinational head read port, and a parallel line-address compare vector for the query.

## Test plan
- Single word push (addr 0x1FC0_0010, wstrb 4'b0011, data 0x0000_BEEF) into an empty buffer -> `wr_req` in cycle 2 with identical fields. Stall `wr_rdy` 3 cycles, then assert it; `empty` rises only after `wr_ok`.
- Four line pushes back-to-back with `DEPTH = 4` -> `push_ready = 0` on the fifth push. Drain order matches push order; `wr_type = 1`, size 2, wstrb 4'hF.
- Line at 0x0000_1230 pending; `query_addr` 0x0000_123C -> `query_hit = 1`. `query_addr` 0x0000_1240 -> `query_hit = 0`. After `wr_ok`, 0x0000_123C -> `query_hit = 0`.
- Full buffer, with `wr_ok` and a push in the same cycle -> push refused, `count` drops to 3, and the next push is accepted.
- `WB_MERGE_EN`: word pushes to 0x100 with wstrb 4'b0001 (data 0xAA) then 4'b0100 (data 0xCC0000) -> one entry with wstrb 4'b0101, data 0x00CC_00AA, size 2.
- `resetn` low during WAIT_OK with 3 entries held -> next cycle `empty = 1`, `wr_req = 0`, FSM in IDLE.
